// File: rtl/mandel_pkg.sv
// Types and constants shared by the Mandelbrot pixel scheduler and its depth calculator.
package mandel_pkg;

    localparam int DEPTH_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } sched_state_t;

endpackage

// File: rtl/pixel_out_reg.sv
// One-entry valid/ready holding register for a finished pixel beat {depth, sof, eol}.
module pixel_out_reg
    import mandel_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DEPTH_W-1:0] depth_i,
    input  logic               sof_i,
    input  logic               eol_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               sof_o,
    output logic               eol_o,
    output logic               free_o
);

    logic               valid_q, valid_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               sof_q, sof_d;
    logic               eol_q, eol_d;

    // The producer only loads when free_o is high, so a load never overwrites an unaccepted beat.
    always_comb begin
        valid_d = valid_q;
        depth_d = depth_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        if (load_i) begin
            valid_d = 1'b1;
            depth_d = depth_i;
            sof_d   = sof_i;
            eol_d   = eol_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            depth_q <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            depth_q <= depth_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign valid_o = valid_q;
    assign depth_o = depth_q;
    assign sof_o   = sof_q;
    assign eol_o   = eol_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/pixel_scheduler.sv
// Raster-order issuer: walks the screen, feeds c to the depth calculator one pixel at a time
// and streams the resulting depths out with start-of-frame / end-of-line markers.
module pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                          sysclk,
    input  logic                          reset_n,
    input  logic                          start_frame,
    input  logic signed [WORD_LENGTH-1:0] re_origin,
    input  logic signed [WORD_LENGTH-1:0] im_origin,
    input  logic signed [WORD_LENGTH-1:0] step,
    input  logic        [7:0]             max_iter,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          calc_start,
    output logic signed [WORD_LENGTH-1:0] calc_re_c,
    output logic signed [WORD_LENGTH-1:0] calc_im_c,
    output logic        [7:0]             calc_max_iter,
    input  logic                          calc_done,
    input  logic        [DEPTH_W-1:0]     calc_depth,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic        [DEPTH_W-1:0]     out_depth,
    output logic                          out_sof,
    output logic                          out_eol
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    if (FRAC >= WORD_LENGTH) begin : g_frac_check
        $error("FRAC must be smaller than WORD_LENGTH");
    end

    sched_state_t                  state_q, state_d;
    logic [XW-1:0]                 x_q, x_d;
    logic [YW-1:0]                 y_q, y_d;
    logic signed [WORD_LENGTH-1:0] re_q, re_d;
    logic signed [WORD_LENGTH-1:0] im_q, im_d;
    logic signed [WORD_LENGTH-1:0] re_org_q, re_org_d;
    logic signed [WORD_LENGTH-1:0] step_q, step_d;
    logic [7:0]                    iter_q, iter_d;

    logic last_x, last_y, load, out_free;

    assign last_x = (x_q == XW'(H_RES - 1));
    assign last_y = (y_q == YW'(V_RES - 1));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        re_d       = re_q;
        im_d       = im_q;
        re_org_d   = re_org_q;
        step_d     = step_q;
        iter_d     = iter_q;
        load       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_frame) begin
                    re_org_d = re_origin;
                    re_d     = re_origin;
                    im_d     = im_origin;
                    step_d   = step;
                    iter_d   = max_iter;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // done is a level, so holding here while the output is occupied loses nothing.
                if (calc_done && out_free) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                    if (last_x) begin
                        x_d  = '0;
                        re_d = re_org_q;
                        if (last_y) begin
                            state_d = DRAIN;
                        end else begin
                            y_d  = y_q + YW'(1);
                            im_d = im_q - step_q;
                        end
                    end else begin
                        x_d  = x_q + XW'(1);
                        re_d = re_q + step_q;
                    end
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            re_q     <= '0;
            im_q     <= '0;
            re_org_q <= '0;
            step_q   <= '0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            re_q     <= re_d;
            im_q     <= im_d;
            re_org_q <= re_org_d;
            step_q   <= step_d;
            iter_q   <= iter_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign calc_start    = (state_q == ISSUE);
    assign calc_re_c     = re_q;
    assign calc_im_c     = im_q;
    assign calc_max_iter = iter_q;

    pixel_out_reg u_out_reg (
        .clk_i   (sysclk),
        .rst_ni  (reset_n),
        .load_i  (load),
        .depth_i (calc_depth),
        .sof_i   ((x_q == '0) && (y_q == '0)),
        .eol_i   (last_x),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .depth_o (out_depth),
        .sof_o   (out_sof),
        .eol_o   (out_eol),
        .free_o  (out_free)
    );

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler on a 4x2 screen with a fixed-latency stub depth calculator.
module tb_pixel_scheduler;

    localparam int HR   = 4;
    localparam int VR   = 2;
    localparam int LAT  = 5;
    localparam int NPIX = HR * VR;

    logic               sysclk      = 1'b0;
    logic               reset_n     = 1'b0;
    logic               start_frame = 1'b0;
    logic signed [31:0] re_origin   = '0;
    logic signed [31:0] im_origin   = '0;
    logic signed [31:0] step        = '0;
    logic [7:0]         max_iter    = '0;
    logic               busy, frame_done, calc_start;
    logic signed [31:0] calc_re_c, calc_im_c;
    logic [7:0]         calc_max_iter;
    logic               calc_done;
    logic [9:0]         calc_depth;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [9:0]         out_depth;
    logic               out_sof, out_eol;

    pixel_scheduler #(
        .WORD_LENGTH(32), .FRAC(28), .H_RES(HR), .V_RES(VR)
    ) dut (
        .sysclk(sysclk), .reset_n(reset_n), .start_frame(start_frame),
        .re_origin(re_origin), .im_origin(im_origin), .step(step), .max_iter(max_iter),
        .busy(busy), .frame_done(frame_done), .calc_start(calc_start),
        .calc_re_c(calc_re_c), .calc_im_c(calc_im_c), .calc_max_iter(calc_max_iter),
        .calc_done(calc_done), .calc_depth(calc_depth),
        .out_valid(out_valid), .out_ready(out_ready), .out_depth(out_depth),
        .out_sof(out_sof), .out_eol(out_eol)
    );

    always #5 sysclk = ~sysclk;

    // Stub calculator: depth = job index within the frame, done after LAT cycles, shares reset_n.
    int unsigned stub_cnt;
    logic [9:0]  stub_jobs;
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            calc_done  <= 1'b0;
            calc_depth <= '0;
            stub_cnt   <= 0;
            stub_jobs  <= '0;
        end else begin
            if (!busy) stub_jobs <= '0;
            if (calc_start) begin
                calc_done  <= 1'b0;
                calc_depth <= stub_jobs;
                stub_jobs  <= stub_jobs + 10'd1;
                stub_cnt   <= LAT;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) calc_done <= 1'b1;
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = toggles every 2 cycles, 2 = ready_man.
    int   ready_mode = 0;
    logic ready_man  = 1'b1;
    int   cyc        = 0;
    always @(posedge sysclk) begin
        #1;
        cyc = cyc + 1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc >> 1) & 1) != 0;
            default: out_ready = ready_man;
        endcase
    end

    logic [31:0] s_re[$], s_im[$];
    logic [9:0]  b_d[$];
    logic        b_sof[$], b_eol[$];
    int          fd_cnt     = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_beat  = '0;
    always @(negedge sysclk) begin
        if (calc_start) begin
            s_re.push_back(calc_re_c);
            s_im.push_back(calc_im_c);
        end
        if (out_valid && out_ready) begin
            b_d.push_back(out_depth);
            b_sof.push_back(out_sof);
            b_eol.push_back(out_eol);
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
        if (prev_stall && reset_n && (!out_valid || {out_depth, out_sof, out_eol} != prev_beat))
            stall_viol = stall_viol + 1;
        prev_stall = out_valid && !out_ready && reset_n;
        prev_beat  = {out_depth, out_sof, out_eol};
    end

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [9:0]  depth;
        logic        sof;
        logic        eol;
    } vec_t;
    vec_t tbl[NPIX];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_calc_start"}, 32'(calc_start), 0);
        check({tag, "_calc_re"}, calc_re_c, 0);
        check({tag, "_calc_im"}, calc_im_c, 0);
        check({tag, "_calc_iter"}, 32'(calc_max_iter), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_depth"}, 32'(out_depth), 0);
        check({tag, "_out_sof"}, 32'(out_sof), 0);
        check({tag, "_out_eol"}, 32'(out_eol), 0);
    endtask

    task automatic start_frm(input logic [31:0] re, input logic [31:0] im,
                             input logic [31:0] st, input logic [7:0] mi);
        @(posedge sysclk);
        #1;
        re_origin   = re;
        im_origin   = im;
        step        = st;
        max_iter    = mi;
        start_frame = 1'b1;
        @(posedge sysclk);
        #1;
        start_frame = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int f0;
        f0 = fd_cnt;
        for (int i = 0; i < budget && fd_cnt == f0; i++) @(posedge sysclk);
        #2;
        check({tag, "_frame_done_pulses"}, 32'(fd_cnt - f0), 1);
    endtask

    task automatic check_frame(input string tag, input int bs, input int bb);
        check({tag, "_n_starts"}, 32'(s_re.size() - bs), NPIX);
        check({tag, "_n_beats"}, 32'(b_d.size() - bb), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (bs + i < s_re.size()) begin
                check($sformatf("%s_re%0d", tag, i), s_re[bs + i], tbl[i].re);
                check($sformatf("%s_im%0d", tag, i), s_im[bs + i], tbl[i].im);
            end
            if (bb + i < b_d.size()) begin
                check($sformatf("%s_depth%0d", tag, i), 32'(b_d[bb + i]), 32'(tbl[i].depth));
                check($sformatf("%s_sof%0d", tag, i), 32'(b_sof[bb + i]), 32'(tbl[i].sof));
                check($sformatf("%s_eol%0d", tag, i), 32'(b_eol[bb + i]), 32'(tbl[i].eol));
            end
        end
    endtask

    localparam logic [31:0] ORG_RE = 32'hE000_0000;
    localparam logic [31:0] ORG_IM = 32'h1000_0000;
    localparam logic [31:0] STEP   = 32'h0800_0000;

    initial begin
        int bs, bb, f0;

        // Q4.28: re -2.0,-1.5,-1.0,-0.5 ; im 1.0 then 0.5 ; depth = pixel index
        tbl[0] = '{32'hE000_0000, 32'h1000_0000, 10'd0, 1'b1, 1'b0};
        tbl[1] = '{32'hE800_0000, 32'h1000_0000, 10'd1, 1'b0, 1'b0};
        tbl[2] = '{32'hF000_0000, 32'h1000_0000, 10'd2, 1'b0, 1'b0};
        tbl[3] = '{32'hF800_0000, 32'h1000_0000, 10'd3, 1'b0, 1'b1};
        tbl[4] = '{32'hE000_0000, 32'h0800_0000, 10'd4, 1'b0, 1'b0};
        tbl[5] = '{32'hE800_0000, 32'h0800_0000, 10'd5, 1'b0, 1'b0};
        tbl[6] = '{32'hF000_0000, 32'h0800_0000, 10'd6, 1'b0, 1'b0};
        tbl[7] = '{32'hF800_0000, 32'h0800_0000, 10'd7, 1'b0, 1'b1};

        repeat (3) @(posedge sysclk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // A: always ready, first-issue timing and max_iter latching
        ready_mode = 0;
        bs = s_re.size(); bb = b_d.size();
        start_frm(ORG_RE, ORG_IM, STEP, 8'd100);
        check("A_first_calc_start", 32'(calc_start), 1);
        check("A_busy_on_accept", 32'(busy), 1);
        check("A_first_re", calc_re_c, ORG_RE);
        check("A_first_im", calc_im_c, ORG_IM);
        check("A_iter_latched", 32'(calc_max_iter), 100);
        max_iter = 8'd7;
        wait_frame("A", 500);
        check("A_iter_held", 32'(calc_max_iter), 100);
        @(posedge sysclk); #1;
        check("A_busy_after", 32'(busy), 0);
        check_frame("A", bs, bb);

        // B: ready toggling every 2 cycles
        ready_mode = 1;
        bs = s_re.size(); bb = b_d.size();
        start_frm(ORG_RE, ORG_IM, STEP, 8'd50);
        wait_frame("B", 800);
        check_frame("B", bs, bb);

        // C: 40-cycle stall right after the first beat appears
        ready_mode = 2;
        ready_man  = 1'b0;
        bs = s_re.size(); bb = b_d.size();
        start_frm(ORG_RE, ORG_IM, STEP, 8'd50);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge sysclk);
        check("C_valid_seen", 32'(out_valid), 1);
        repeat (40) @(posedge sysclk);
        #2;
        check("C_starts_in_stall", 32'(s_re.size() - bs), 2);
        check("C_valid_held", 32'(out_valid), 1);
        check("C_depth_held", 32'(out_depth), 0);
        check("C_sof_held", 32'(out_sof), 1);
        check("C_busy_in_stall", 32'(busy), 1);
        check("C_no_accept", 32'(b_d.size() - bb), 0);
        ready_man = 1'b1;
        wait_frame("C", 800);
        check_frame("C", bs, bb);

        // D: start_frame while busy and coincident with frame_done is ignored
        ready_mode = 0;
        bs = s_re.size(); bb = b_d.size(); f0 = fd_cnt;
        start_frm(ORG_RE, ORG_IM, STEP, 8'd50);
        repeat (10) @(posedge sysclk);
        #1;
        re_origin   = 32'h0;
        start_frame = 1'b1;
        @(posedge sysclk); #1;
        start_frame = 1'b0;
        for (int i = 0; i < 500 && !frame_done; i++) @(negedge sysclk);
        check("D_frame_done_seen", 32'(frame_done), 1);
        check("D_busy_at_done", 32'(busy), 1);
        start_frame = 1'b1;
        @(posedge sysclk); #1;
        start_frame = 1'b0;
        check("D_busy_falls", 32'(busy), 0);
        repeat (10) @(posedge sysclk);
        #1;
        check("D_still_idle", 32'(busy), 0);
        check("D_one_done", 32'(fd_cnt - f0), 1);
        check_frame("D", bs, bb);

        // E: reset during WAIT aborts the frame, then a clean restart
        start_frm(ORG_RE, ORG_IM, STEP, 8'd50);
        repeat (10) @(posedge sysclk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("E_async");
        @(posedge sysclk); #1;
        check_reset_outputs("E_held");
        reset_n = 1'b1;
        bs = s_re.size(); bb = b_d.size();
        start_frm(ORG_RE, ORG_IM, STEP, 8'd50);
        wait_frame("E", 500);
        check_frame("E", bs, bb);

        // F: re accumulator wraps modulo 2^32
        bs = s_re.size();
        start_frm(32'h7FFF_FFFF, 32'h0, 32'h1, 8'd10);
        check("F_iter", 32'(calc_max_iter), 10);
        wait_frame("F", 500);
        check("F_n_starts", 32'(s_re.size() - bs), NPIX);
        if (s_re.size() >= bs + NPIX) begin
            check("F_re1_wrap", s_re[bs + 1], 32'h8000_0000);
            check("F_re3", s_re[bs + 3], 32'h8000_0002);
            check("F_re4_reload", s_re[bs + 4], 32'h7FFF_FFFF);
            check("F_im4", s_im[bs + 4], 32'hFFFF_FFFF);
        end

        check("stall_stable", 32'(stall_viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_scheduler.md
# pixel_scheduler

Raster-order work issuer that sits directly upstream of the depth calculator. It walks an H_RES×V_RES screen and derives each pixel's complex coordinate c incrementally from a latched origin and step. It hands c to the depth calculator with a single-cycle start pulse and collects final_depth on done. Results leave on a valid/ready pixel stream with start-of-frame and end-of-line markers for the colour/video stage.

## Interface
- WORD_LENGTH, 32, fixed-point word width of coordinates; must match the depth calculator.
- FRAC, 28, fractional bits of coordinates (informational; no scaling in this block).
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- sysclk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- start_frame  in  1  begin a frame; sampled only in IDLE.
- re_origin, im_origin  in  WORD_LENGTH  signed c of pixel (0,0), the top-left pixel.
- step  in  WORD_LENGTH  signed per-pixel increment.
- max_iter  in  8  iteration limit, latched per frame.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  one-cycle pulse when the last pixel beat is accepted.
- calc_start  out  1  one-cycle start pulse to the depth calculator.
- calc_re_c, calc_im_c  out  WORD_LENGTH  c for the current job; held stable until the job's done is seen.
- calc_max_iter  out  8  latched max_iter.
- calc_done  in  1  depth calculator done; level, stays high until the next start.
- calc_depth  in  10  depth calculator final_depth.
- out_valid  out  1  pixel beat valid.
- out_ready  in  1  downstream accepts.
- out_depth  out  10  pixel depth.
- out_sof  out  1  beat is pixel (0,0).
- out_eol  out  1  beat is the last pixel of a line (x = H_RES-1).

## Operation
- Frame acceptance: in IDLE, start_frame latches origin, step and max_iter and clears x, y. Inputs are ignored at all other times.
- Coordinates are generated by accumulation, with no multipliers:
  - re accumulator: +step per pixel; reloaded to re_origin at the start of each line.
  - im accumulator: −step per line (screen y grows downward).
  - All adds wrap modulo 2^WORD_LENGTH with no saturation.
- FSM:
  - IDLE→ISSUE on start_frame.
  - ISSUE: calc_start=1 for exactly one cycle, then →WAIT.
  - WAIT: when calc_done=1 and the output register is free (empty, or being drained this cycle), capture calc_depth with x/y flags, then go to ISSUE for the next pixel, or to DRAIN after the last pixel.
  - If calc_done=1 but the register is occupied, remain in WAIT. This is safe because done is a level.
  - DRAIN: when the final beat is accepted, pulse frame_done and go →IDLE.
- Output register holds one beat. out_* stay stable while out_valid && !out_ready. Accepted on out_valid && out_ready.
- The depth calculator's own reset must be driven from the same source so both reset together.
- Reset mid-frame aborts the frame; no partial beat survives.

## Timing
- Reset values: every output is 0, and state is IDLE.
- First calc_start occurs 1 cycle after start_frame is sampled, with c = (re_origin, im_origin).
- calc_done is ignored in ISSUE. WAIT is entered the cycle after the pulse, when the calculator has already cleared done.
- out_valid rises 1 cycle after the WAIT capture edge.
- The next calc_start follows the capture by 1 cycle, overlapping output backpressure.
- Pixel period = calculator latency + 2 cycles when out_ready=1.
- A beat at x=H_RES-1 sets out_eol; the pixel at (H_RES-1, V_RES-1) also moves the FSM to DRAIN.
- start_frame arriving in the same cycle as frame_done is ignored (state is not IDLE yet).

## Structure
- Shared package mandel_pkg: sched_state_t enum (IDLE, ISSUE, WAIT, DRAIN) and the depth width constant DEPTH_W=10.
- One sub-module, pixel_out_reg: a one-entry valid/ready holding register for {depth, sof, eol}.

## Test plan
- Reset mid-frame: reset_n low during WAIT → all outputs 0 next cycle; state IDLE; new start_frame restarts at (0,0).
- H_RES=4, V_RES=2, origin (−2.0, 1.0), step 0.5, stub calculator with 5-cycle latency, out_ready=1 → 8 beats, calc c sequence re −2,−1.5,−1,−0.5 and im 1.0 then 0.5; sof on beat 0; eol on beats 3 and 7; one frame_done pulse.
- Stub returns depth = pixel index and out_ready toggles every 2 cycles → depths 0..7 in order, none lost or duplicated; out_* stable while stalled.
- out_ready=0 for 40 cycles after the first beat → exactly one extra calc_start issued, then the FSM holds in WAIT; everything resumes in order when ready rises.
- start_frame pulsed while busy → ignored; frame completes unchanged; busy falls with frame_done.
- re_origin=0x7FFFFFFF, step=1 → calc_re_c wraps to 0x80000000 on pixel 1.
